// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decode-side inputs, fetch-control feedback and EX-side registered outputs.
// The master drives the decode side; the slave is the pipeline register.
interface id_ex_stage_if #(
  parameter int CNT_W = 16
);
  logic              id_valid;
  logic [31:0]       id_instr;
  logic [31:0]       id_pc_plus4;
  logic [31:0]       id_rdata1;
  logic [31:0]       id_rdata2;
  logic [3:0]        control_exe;
  logic [2:0]        control_mem;
  logic [1:0]        control_wb;
  logic              control_exception;
  logic [1:0]        control_out_datamem;
  logic [1:0]        control_out_reg2;
  logic              flush;
  logic              hold;
  logic              exc_ack;

  logic              pc_write;
  logic              ifid_write;
  logic [3:0]        ex_exe;
  logic [2:0]        ex_mem;
  logic [1:0]        ex_wb;
  logic [1:0]        ex_datamem;
  logic [1:0]        ex_reg2;
  logic [31:0]       ex_pc_plus4;
  logic [31:0]       ex_rdata1;
  logic [31:0]       ex_rdata2;
  logic [31:0]       ex_imm;
  logic [4:0]        ex_rs;
  logic [4:0]        ex_rt;
  logic [4:0]        ex_rd;
  logic              ex_valid;
  logic              exc_valid;
  logic [31:0]       exc_epc;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output id_valid, id_instr, id_pc_plus4, id_rdata1, id_rdata2,
           control_exe, control_mem, control_wb, control_exception,
           control_out_datamem, control_out_reg2, flush, hold, exc_ack,
    input  pc_write, ifid_write, ex_exe, ex_mem, ex_wb, ex_datamem, ex_reg2,
           ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_valid, exc_valid, exc_epc, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_instr, id_pc_plus4, id_rdata1, id_rdata2,
           control_exe, control_mem, control_wb, control_exception,
           control_out_datamem, control_out_reg2, flush, hold, exc_ack,
    output pc_write, ifid_write, ex_exe, ex_mem, ex_wb, ex_datamem, ex_reg2,
           ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_valid, exc_valid, exc_epc, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch/jump flush, exception
// hold-off with ack handshake, and saturating stall/flush event counters.
module id_ex_stage #(
  parameter int CNT_W      = 16,
  parameter int EPC_OFFSET = 4
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  typedef enum logic {RUN, EXC_WAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t      state;
  logic [5:0]  opcode;
  logic        uses_rt;
  logic        hazard;
  logic [31:0] imm_ext;
  logic        advance;
  logic        freeze;
  logic        take_exc;
  logic        stall_ev;
  logic        flush_ev;
  logic        load_ctl;

  always_comb begin
    opcode  = bus.id_instr[31:26];
    uses_rt = opcode inside {6'd0, 6'd4, 6'd5, 6'd40, 6'd41, 6'd43};
    // andi/ori treat the immediate as unsigned; everything else sign-extends.
    imm_ext = (opcode == 6'd12 || opcode == 6'd13) ?
              {16'h0000, bus.id_instr[15:0]} :
              {{16{bus.id_instr[15]}}, bus.id_instr[15:0]};
    hazard  = bus.ex_valid && bus.ex_mem[0] && (bus.ex_rt != 5'd0) && bus.id_valid &&
              ((bus.ex_rt == bus.id_instr[25:21]) ||
               ((bus.ex_rt == bus.id_instr[20:16]) && uses_rt));
  end

  // NOTE: every signal gets a default before the priority chain so no path leaves one unassigned (no latches).
  always_comb begin
    advance  = 1'b0;
    freeze   = 1'b0;
    take_exc = 1'b0;
    stall_ev = 1'b0;
    flush_ev = 1'b0;
    load_ctl = 1'b0;
    if (state == EXC_WAIT) begin
      // The ack always resumes fetch; hold only freezes the EX registers.
      freeze   = bus.hold;
      flush_ev = bus.flush;
      advance  = bus.exc_ack;
    end else if (bus.flush) begin
      flush_ev = 1'b1;
      advance  = 1'b1;
    end else if (bus.hold) begin
      freeze = 1'b1;
    end else if (bus.id_valid && bus.control_exception) begin
      take_exc = 1'b1;
    end else if (hazard) begin
      stall_ev = 1'b1;
    end else begin
      load_ctl = 1'b1;
      advance  = 1'b1;
    end
  end

  assign bus.pc_write   = advance;
  assign bus.ifid_write = advance;

  // NOTE: reset is sampled on the clock edge and state updates use non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= RUN;
      bus.ex_exe      <= '0;
      bus.ex_mem      <= '0;
      bus.ex_wb       <= '0;
      bus.ex_datamem  <= '0;
      bus.ex_reg2     <= '0;
      bus.ex_pc_plus4 <= '0;
      bus.ex_rdata1   <= '0;
      bus.ex_rdata2   <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rs       <= '0;
      bus.ex_rt       <= '0;
      bus.ex_rd       <= '0;
      bus.ex_valid    <= 1'b0;
      bus.exc_valid   <= 1'b0;
      bus.exc_epc     <= '0;
      bus.stall_cnt   <= '0;
      bus.flush_cnt   <= '0;
    end else begin
      if (!freeze) begin
        // Data and index fields always load; a bubble only clears the control bundles.
        bus.ex_pc_plus4 <= bus.id_pc_plus4;
        bus.ex_rdata1   <= bus.id_rdata1;
        bus.ex_rdata2   <= bus.id_rdata2;
        bus.ex_imm      <= imm_ext;
        bus.ex_rs       <= bus.id_instr[25:21];
        bus.ex_rt       <= bus.id_instr[20:16];
        bus.ex_rd       <= bus.id_instr[15:11];
        bus.ex_exe      <= load_ctl ? bus.control_exe         : 4'd0;
        bus.ex_mem      <= load_ctl ? bus.control_mem         : 3'd0;
        bus.ex_wb       <= load_ctl ? bus.control_wb          : 2'd0;
        bus.ex_datamem  <= load_ctl ? bus.control_out_datamem : 2'd0;
        bus.ex_reg2     <= load_ctl ? bus.control_out_reg2    : 2'd0;
        bus.ex_valid    <= load_ctl & bus.id_valid;
      end

      if (stall_ev && bus.stall_cnt != CNT_MAX)
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      if (flush_ev && bus.flush_cnt != CNT_MAX)
        bus.flush_cnt <= bus.flush_cnt + CNT_W'(1);

      if (take_exc) begin
        bus.exc_valid <= 1'b1;
        bus.exc_epc   <= bus.id_pc_plus4 - 32'(EPC_OFFSET);
        state         <= EXC_WAIT;
      end else if (state == EXC_WAIT && bus.exc_ack) begin
        bus.exc_valid <= 1'b0;
        state         <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed vector table, hand-written corner
// sequences, and randomized traffic against a behavioural model (plus a CNT_W=2 copy for saturation).
module tb_id_ex_stage;

  logic clk;
  logic rst_n;

  id_ex_stage_if #(.CNT_W(16)) bus ();
  id_ex_stage_if #(.CNT_W(2))  sbus ();

  id_ex_stage #(.CNT_W(16), .EPC_OFFSET(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  id_ex_stage #(.CNT_W(2),  .EPC_OFFSET(4)) dut_sat (.clk(clk), .rst_n(rst_n), .bus(sbus));

  assign sbus.id_valid            = bus.id_valid;
  assign sbus.id_instr            = bus.id_instr;
  assign sbus.id_pc_plus4         = bus.id_pc_plus4;
  assign sbus.id_rdata1           = bus.id_rdata1;
  assign sbus.id_rdata2           = bus.id_rdata2;
  assign sbus.control_exe         = bus.control_exe;
  assign sbus.control_mem         = bus.control_mem;
  assign sbus.control_wb          = bus.control_wb;
  assign sbus.control_exception   = bus.control_exception;
  assign sbus.control_out_datamem = bus.control_out_datamem;
  assign sbus.control_out_reg2    = bus.control_out_reg2;
  assign sbus.flush               = bus.flush;
  assign sbus.hold                = bus.hold;
  assign sbus.exc_ack             = bus.exc_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic        id_valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  exe;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic        exc;
    logic [1:0]  dm;
    logic [1:0]  r2;
    logic        flush;
    logic        hold;
    logic        ack;
  } in_t;

  typedef struct packed {
    logic [3:0]  exe;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [1:0]  dm;
    logic [1:0]  r2;
    logic [31:0] pc4;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        valid;
    logic        exc_valid;
    logic [31:0] epc;
    logic [31:0] stall;
    logic [31:0] flsh;
    logic [31:0] stall_s;
    logic [31:0] flsh_s;
    logic        in_exc;
  } st_t;

  typedef struct {
    in_t         v;
    logic        pcw;
    logic        valid;
    logic [3:0]  exe;
    logic [2:0]  mem;
    logic [31:0] stall;
  } row_t;

  localparam logic [3:0] LW_EXE   = 4'b0010;
  localparam logic [2:0] LW_MEM   = 3'b001;
  localparam logic [1:0] LW_WB    = 2'b11;
  localparam logic [3:0] ADD_EXE  = 4'b1001;
  localparam logic [3:0] ADDI_EXE = 4'b0010;
  localparam logic [3:0] ANDI_EXE = 4'b1110;
  localparam logic [2:0] SW_MEM   = 3'b010;

  int    n_checks = 0;
  int    n_pass   = 0;
  string ctx      = "init";
  logic  pcw_seen;
  st_t   m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", ctx, name, act, exp, $time);
  endtask

  function automatic logic [31:0] itype(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rtype(int rs, int rt, int rd, int funct);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, funct[5:0]};
  endfunction

  function automatic in_t mk(logic valid, logic [31:0] instr, logic [3:0] exe,
                             logic [2:0] mem, logic [1:0] wb);
    in_t v = '0;
    v.rst_n    = 1'b1;
    v.id_valid = valid;
    v.instr    = instr;
    v.pc4      = 32'h0000_0100;
    v.rd1      = 32'hA5A5_0001;
    v.rd2      = 32'h5A5A_0002;
    v.exe      = exe;
    v.mem      = mem;
    v.wb       = wb;
    return v;
  endfunction

  // ---------------- behavioural reference model ----------------
  function automatic logic [31:0] imm_of(logic [31:0] instr);
    int op = int'(instr[31:26]);
    int lo = int'(instr[15:0]);
    if (op == 12 || op == 13) return 32'(lo);
    return 32'((lo >= 32768) ? lo - 65536 : lo);
  endfunction

  function automatic bit load_use(st_t s, in_t v);
    int op = int'(v.instr[31:26]);
    bit reads_rt = op inside {0, 4, 5, 40, 41, 43};
    if (!(s.valid && s.mem[0] && s.rt != 0 && v.id_valid)) return 1'b0;
    return (s.rt == v.instr[25:21]) || (reads_rt && s.rt == v.instr[20:16]);
  endfunction

  function automatic st_t take_data(st_t s, in_t v, bit with_ctl);
    st_t n = s;
    n.pc4 = v.pc4;  n.rd1 = v.rd1;  n.rd2 = v.rd2;
    n.imm = imm_of(v.instr);
    n.rs  = v.instr[25:21];  n.rt = v.instr[20:16];  n.rd = v.instr[15:11];
    n.exe   = with_ctl ? v.exe : 4'd0;
    n.mem   = with_ctl ? v.mem : 3'd0;
    n.wb    = with_ctl ? v.wb  : 2'd0;
    n.dm    = with_ctl ? v.dm  : 2'd0;
    n.r2    = with_ctl ? v.r2  : 2'd0;
    n.valid = with_ctl && v.id_valid;
    return n;
  endfunction

  function automatic st_t count_flush(st_t s);
    st_t n = s;
    if (n.flsh < 65535) n.flsh = n.flsh + 1;
    if (n.flsh_s < 3) n.flsh_s = n.flsh_s + 1;
    return n;
  endfunction

  function automatic bit model_pcw(st_t s, in_t v);
    if (s.in_exc) return v.ack;
    if (v.flush) return 1'b1;
    if (v.hold) return 1'b0;
    if (v.id_valid && v.exc) return 1'b0;
    return !load_use(s, v);
  endfunction

  function automatic st_t model_next(st_t s, in_t v);
    st_t n = s;
    if (!v.rst_n) return '0;
    if (s.in_exc) begin
      if (v.flush) n = count_flush(n);
      if (!v.hold) n = take_data(n, v, 1'b0);
      if (v.ack) begin
        n.exc_valid = 1'b0;
        n.in_exc    = 1'b0;
      end
    end else if (v.flush) begin
      n = take_data(count_flush(n), v, 1'b0);
    end else if (v.hold) begin
      n = s;
    end else if (v.id_valid && v.exc) begin
      n = take_data(n, v, 1'b0);
      n.exc_valid = 1'b1;
      n.epc       = v.pc4 - 32'd4;
      n.in_exc    = 1'b1;
    end else if (load_use(s, v)) begin
      n = take_data(n, v, 1'b0);
      if (n.stall < 65535) n.stall = n.stall + 1;
      if (n.stall_s < 3) n.stall_s = n.stall_s + 1;
    end else begin
      n = take_data(n, v, 1'b1);
    end
    return n;
  endfunction

  // ---------------- drive / compare ----------------
  task automatic apply(input in_t v);
    rst_n                   = v.rst_n;
    bus.id_valid            = v.id_valid;
    bus.id_instr            = v.instr;
    bus.id_pc_plus4         = v.pc4;
    bus.id_rdata1           = v.rd1;
    bus.id_rdata2           = v.rd2;
    bus.control_exe         = v.exe;
    bus.control_mem         = v.mem;
    bus.control_wb          = v.wb;
    bus.control_exception   = v.exc;
    bus.control_out_datamem = v.dm;
    bus.control_out_reg2    = v.r2;
    bus.flush               = v.flush;
    bus.hold                = v.hold;
    bus.exc_ack             = v.ack;
  endtask

  task automatic cmp_model();
    check("ex_exe",      bus.ex_exe,      m.exe);
    check("ex_mem",      bus.ex_mem,      m.mem);
    check("ex_wb",       bus.ex_wb,       m.wb);
    check("ex_datamem",  bus.ex_datamem,  m.dm);
    check("ex_reg2",     bus.ex_reg2,     m.r2);
    check("ex_pc_plus4", bus.ex_pc_plus4, m.pc4);
    check("ex_rdata1",   bus.ex_rdata1,   m.rd1);
    check("ex_rdata2",   bus.ex_rdata2,   m.rd2);
    check("ex_imm",      bus.ex_imm,      m.imm);
    check("ex_rs",       bus.ex_rs,       m.rs);
    check("ex_rt",       bus.ex_rt,       m.rt);
    check("ex_rd",       bus.ex_rd,       m.rd);
    check("ex_valid",    bus.ex_valid,    m.valid);
    check("exc_valid",   bus.exc_valid,   m.exc_valid);
    check("exc_epc",     bus.exc_epc,     m.epc);
    check("stall_cnt",   bus.stall_cnt,   m.stall);
    check("flush_cnt",   bus.flush_cnt,   m.flsh);
    check("sat_stall",   sbus.stall_cnt,  m.stall_s);
    check("sat_flush",   sbus.flush_cnt,  m.flsh_s);
  endtask

  // One clock: drive after the edge, sample fetch enables mid-cycle, compare registers after the edge.
  task automatic cycle(input in_t v);
    bit exp_pcw;
    apply(v);
    exp_pcw = model_pcw(m, v);
    @(negedge clk);
    pcw_seen = bus.pc_write;
    if (v.rst_n) begin
      check("pc_write",   bus.pc_write,   exp_pcw);
      check("ifid_write", bus.ifid_write, exp_pcw);
    end
    m = model_next(m, v);
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    in_t v = '0;
    cycle(v);
  endtask

  row_t tbl[12];

  initial begin
    in_t v;
    in_t lw8;
    in_t add_dep;
    m = '0;
    apply('0);
    @(posedge clk);
    #1;

    // Reset state.
    ctx = "reset";
    do_reset();
    check("rst_ex_valid",  bus.ex_valid,  1'b0);
    check("rst_exc_valid", bus.exc_valid, 1'b0);
    check("rst_ex_imm",    bus.ex_imm,    32'h0);
    check("rst_stall",     bus.stall_cnt, 16'h0);

    lw8     = mk(1'b1, itype(35, 9, 8, 0), LW_EXE, LW_MEM, LW_WB);
    add_dep = mk(1'b1, rtype(8, 11, 10, 32), ADD_EXE, 3'd0, 2'b01);

    // Load-use and no-false-stall vectors.
    tbl[0]  = '{lw8,     1'b1, 1'b1, LW_EXE,   LW_MEM, 32'd0};
    tbl[1]  = '{add_dep, 1'b0, 1'b0, 4'd0,     3'd0,   32'd1};
    tbl[2]  = '{add_dep, 1'b1, 1'b1, ADD_EXE,  3'd0,   32'd1};
    tbl[3]  = '{mk(1'b1, itype(35, 9, 0, 4), LW_EXE, LW_MEM, LW_WB),
                         1'b1, 1'b1, LW_EXE,   LW_MEM, 32'd1};
    tbl[4]  = '{mk(1'b1, rtype(0, 0, 10, 32), ADD_EXE, 3'd0, 2'b01),
                         1'b1, 1'b1, ADD_EXE,  3'd0,   32'd1};
    tbl[5]  = '{mk(1'b1, itype(8, 9, 8, 1), ADDI_EXE, 3'd0, 2'b01),
                         1'b1, 1'b1, ADDI_EXE, 3'd0,   32'd1};
    tbl[6]  = '{add_dep, 1'b1, 1'b1, ADD_EXE,  3'd0,   32'd1};
    tbl[7]  = '{lw8,     1'b1, 1'b1, LW_EXE,   LW_MEM, 32'd1};
    tbl[8]  = '{mk(1'b1, itype(43, 9, 8, 0), ADDI_EXE, SW_MEM, 2'b00),
                         1'b0, 1'b0, 4'd0,     3'd0,   32'd2};
    tbl[9]  = '{mk(1'b1, itype(43, 9, 8, 0), ADDI_EXE, SW_MEM, 2'b00),
                         1'b1, 1'b1, ADDI_EXE, SW_MEM, 32'd2};
    tbl[10] = '{lw8,     1'b1, 1'b1, LW_EXE,   LW_MEM, 32'd2};
    tbl[11] = '{mk(1'b1, itype(8, 9, 8, 5), ADDI_EXE, 3'd0, 2'b01),
                         1'b1, 1'b1, ADDI_EXE, 3'd0,   32'd2};

    for (int i = 0; i < 12; i++) begin
      ctx = $sformatf("vec%0d", i);
      cycle(tbl[i].v);
      check("t_pcw",   pcw_seen,      tbl[i].pcw);
      check("t_valid", bus.ex_valid,  tbl[i].valid);
      check("t_exe",   bus.ex_exe,    tbl[i].exe);
      check("t_mem",   bus.ex_mem,    tbl[i].mem);
      check("t_stall", bus.stall_cnt, tbl[i].stall);
    end

    // Flush wins over hazard and exception together.
    ctx = "flush_prio";
    do_reset();
    cycle(lw8);
    v = add_dep;
    v.exc   = 1'b1;
    v.flush = 1'b1;
    cycle(v);
    check("f_pcw",   pcw_seen,      1'b1);
    check("f_valid", bus.ex_valid,  1'b0);
    check("f_mem",   bus.ex_mem,    3'd0);
    check("f_flush", bus.flush_cnt, 16'd1);
    check("f_stall", bus.stall_cnt, 16'd0);
    check("f_exc",   bus.exc_valid, 1'b0);
    cycle(add_dep);
    check("f_run_pcw",   pcw_seen,     1'b1);
    check("f_run_valid", bus.ex_valid, 1'b1);

    // Exception handshake with a three-cycle wait before the ack.
    ctx = "exc";
    do_reset();
    v = mk(1'b1, itype(8, 1, 2, 3), ADDI_EXE, 3'd0, 2'b01);
    v.exc = 1'b1;
    v.pc4 = 32'h0000_0044;
    cycle(v);
    check("e_pcw0",  pcw_seen,      1'b0);
    check("e_valid", bus.exc_valid, 1'b1);
    check("e_epc",   bus.exc_epc,   32'h0000_0040);
    for (int k = 0; k < 2; k++) begin
      cycle(add_dep);
      check("e_wait_pcw",   pcw_seen,      1'b0);
      check("e_wait_valid", bus.exc_valid, 1'b1);
      check("e_wait_epc",   bus.exc_epc,   32'h0000_0040);
      check("e_wait_ex",    bus.ex_valid,  1'b0);
    end
    v = add_dep;
    v.ack = 1'b1;
    cycle(v);
    check("e_ack_pcw", pcw_seen,      1'b1);
    check("e_ack_exc", bus.exc_valid, 1'b0);
    check("e_ack_ex",  bus.ex_valid,  1'b0);
    cycle(add_dep);
    check("e_run_pcw", pcw_seen,     1'b1);
    check("e_run_ex",  bus.ex_valid, 1'b1);

    // Hold freezes EX; immediate extension for andi/addi/ori.
    ctx = "hold_imm";
    do_reset();
    cycle(mk(1'b1, itype(8, 9, 8, 16'h1234), ADDI_EXE, 3'd0, 2'b01));
    v = mk(1'b1, itype(12, 9, 10, 16'h8000), ANDI_EXE, 3'd0, 2'b01);
    v.hold = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle(v);
      check("h_pcw", pcw_seen,    1'b0);
      check("h_imm", bus.ex_imm,  32'h0000_1234);
      check("h_exe", bus.ex_exe,  ADDI_EXE);
    end
    v.hold = 1'b0;
    cycle(v);
    check("andi_imm", bus.ex_imm, 32'h0000_8000);
    check("andi_exe", bus.ex_exe, ANDI_EXE);
    cycle(mk(1'b1, itype(8, 9, 10, 16'h8000), ADDI_EXE, 3'd0, 2'b01));
    check("addi_imm", bus.ex_imm, 32'hFFFF_8000);
    cycle(mk(1'b1, itype(13, 9, 10, 16'hFFFF), ANDI_EXE, 3'd0, 2'b01));
    check("ori_imm",  bus.ex_imm, 32'h0000_FFFF);

    // Reset while waiting for the exception ack.
    ctx = "rst_exc";
    do_reset();
    v = mk(1'b1, itype(8, 1, 2, 3), ADDI_EXE, 3'd0, 2'b01);
    v.exc = 1'b1;
    cycle(v);
    cycle(add_dep);
    v = add_dep;
    v.rst_n = 1'b0;
    v.ack   = 1'b0;
    cycle(v);
    check("r_exc",   bus.exc_valid, 1'b0);
    check("r_epc",   bus.exc_epc,   32'h0);
    check("r_valid", bus.ex_valid,  1'b0);
    check("r_pc4",   bus.ex_pc_plus4, 32'h0);
    cycle(add_dep);
    check("r_run_pcw", pcw_seen, 1'b1);

    // Counter saturation at CNT_W=2 alongside the 16-bit instance.
    ctx = "sat";
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(lw8);
      cycle(add_dep);
    end
    check("sat_stall3",  sbus.stall_cnt, 2'd3);
    check("wide_stall5", bus.stall_cnt,  16'd5);
    v = add_dep;
    v.flush = 1'b1;
    for (int k = 0; k < 4; k++) cycle(v);
    check("sat_flush3",  sbus.flush_cnt, 2'd3);
    check("wide_flush4", bus.flush_cnt,  16'd4);

    // Randomized traffic against the model.
    ctx = "rand";
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      int ops[10] = '{0, 4, 5, 8, 12, 13, 35, 40, 41, 43};
      int regs[4] = '{0, 8, 9, 8};
      int op;
      op = ops[$urandom_range(0, 9)];
      v = '0;
      v.rst_n    = ($urandom_range(0, 199) != 0);
      v.id_valid = ($urandom_range(0, 99) < 85);
      v.instr    = {op[5:0], 5'(regs[$urandom_range(0, 3)]), 5'(regs[$urandom_range(0, 3)]),
                    16'($urandom)};
      v.pc4      = $urandom;
      v.rd1      = $urandom;
      v.rd2      = $urandom;
      v.exe      = 4'($urandom);
      v.mem      = 3'($urandom);
      v.wb       = 2'($urandom);
      v.dm       = 2'($urandom);
      v.r2       = 2'($urandom);
      v.exc      = ($urandom_range(0, 99) < 5);
      v.flush    = ($urandom_range(0, 99) < 10);
      v.hold     = ($urandom_range(0, 99) < 15);
      v.ack      = ($urandom_range(0, 99) < 30);
      cycle(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
